// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks in-flight destinations and their remaining Tnew, raises the
// decode stall, picks the youngest ready forwarding source for rs/rt, and tracks mult/div occupancy.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int TW       = 2,
    parameter int NSTAGE   = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    localparam int SW      = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_read_rs,
    input  logic              d_read_rt,
    input  logic [TW-1:0]     d_tuse_rs,
    input  logic [TW-1:0]     d_tuse_rt,
    input  logic [REG_AW-1:0] d_a3,
    input  logic [TW-1:0]     d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [SW-1:0]     fwd_rs_sel,
    output logic [SW-1:0]     fwd_rt_sel,
    output logic              md_busy
);

    localparam int MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    logic [REG_AW-1:0] a3_q   [NSTAGE];
    logic [TW-1:0]     tnew_q [NSTAGE];
    logic              md_start_e_q, md_start_e_d;
    logic              md_div_e_q;
    logic [CW-1:0]     md_cnt_q, md_cnt_d;

    logic              rs_hit, rt_hit;
    logic [TW-1:0]     rs_tnew, rt_tnew;
    logic [SW-1:0]     rs_sel, rt_sel;
    logic              stall_rs, stall_rt, busy_int, stall_int;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Scan oldest to youngest so the youngest matching entry overwrites any older one.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_tnew = '0;
        rt_tnew = '0;
        rs_sel  = '0;
        rt_sel  = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (d_rs != '0 && a3_q[k] == d_rs) begin
                rs_hit  = 1'b1;
                rs_tnew = tnew_q[k];
                rs_sel  = (tnew_q[k] == '0) ? SW'(k + 1) : '0;
            end
            if (d_rt != '0 && a3_q[k] == d_rt) begin
                rt_hit  = 1'b1;
                rt_tnew = tnew_q[k];
                rt_sel  = (tnew_q[k] == '0) ? SW'(k + 1) : '0;
            end
        end
    end

    // A Tuse of all ones marks an operand that is not consumed in this pipeline.
    assign stall_rs  = d_read_rs && rs_hit && (d_tuse_rs != '1) && (rs_tnew > d_tuse_rs);
    assign stall_rt  = d_read_rt && rt_hit && (d_tuse_rt != '1) && (rt_tnew > d_tuse_rt);
    assign busy_int  = md_start_e_q || (md_cnt_q != '0);
    assign stall_int = stall_rs || stall_rt || (d_md_use && busy_int);

    always_comb begin
        md_start_e_d = d_md_start && !stall_int;
        md_cnt_d     = md_cnt_q;
        if (md_start_e_q) begin
            md_cnt_d = md_div_e_q ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                a3_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
            md_start_e_q <= 1'b0;
            md_cnt_q     <= '0;
        end else begin
            a3_q[0]   <= stall_int ? '0 : d_a3;
            tnew_q[0] <= stall_int ? '0 : sat_dec(d_tnew);
            for (int k = 1; k < NSTAGE; k++) begin
                a3_q[k]   <= a3_q[k-1];
                tnew_q[k] <= sat_dec(tnew_q[k-1]);
            end
            md_start_e_q <= md_start_e_d;
            md_cnt_q     <= md_cnt_d;
            md_div_e_q   <= d_md_div;
        end
    end

    assign stall      = !reset && stall_int;
    assign fwd_rs_sel = reset ? '0 : rs_sel;
    assign fwd_rt_sel = reset ? '0 : rt_sel;
    assign md_busy    = !reset && busy_int;

endmodule
